im_loader: RTL and testbench

//  Writer side of the instruction-memory port. Streams a program image (32-bit words, valid/ready) into the IM.

---
 rtl/im_loader_pkg.sv | 26 ++
 rtl/im_loader_if.sv | 30 +++
 rtl/im_loader_xsum.sv | 30 +++
 rtl/im_loader.sv | 149 ++++++++++++++
 tb/tb_im_loader.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/im_loader_pkg.sv
// ============================================================================
// im_loader_pkg : shared types and sizing helpers for the IM image loader
// Rev 1.0
// ============================================================================
`default_nettype none

package im_loader_pkg;

  localparam int WORD_W           = 32;
  localparam int IM_DEPTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    VERIFY = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Width of an index into a DEPTH-word image (at least one bit).
  function automatic int cnt_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/im_loader_if.sv
// ============================================================================
// im_loader_if : program-word stream plus IM write/read port
// Rev 1.0
// ============================================================================
`default_nettype none

interface im_loader_if;
  import im_loader_pkg::*;

  logic              in_valid;
  logic [WORD_W-1:0] in_data;
  logic              in_ready;
  logic [31:0]       im_addr;
  logic              im_memWrite;
  logic [WORD_W-1:0] im_dataIn;
  logic [WORD_W-1:0] im_rdata;

  modport master (
    input  in_valid, in_data, im_rdata,
    output in_ready, im_addr, im_memWrite, im_dataIn
  );

  modport slave (
    output in_valid, in_data, im_rdata,
    input  in_ready, im_addr, im_memWrite, im_dataIn
  );

endinterface

`default_nettype wire

// File: rtl/im_loader_xsum.sv
// ============================================================================
// im_loader_xsum : 32-bit XOR accumulator with synchronous clear and enable
// Rev 1.0
// ============================================================================
`default_nettype none

module im_loader_xsum
  import im_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              en,
  input  logic [WORD_W-1:0] din,
  output logic [WORD_W-1:0] sum
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum <= '0;
    end else if (clr) begin
      sum <= '0;
    end else if (en) begin
      sum <= sum ^ din;
    end
  end

endmodule

`default_nettype wire

// File: rtl/im_loader.sv
// ============================================================================
// im_loader : streams a program image into the IM, holding the core meanwhile
// Optional readback check enabled by macro IM_LOADER_VERIFY_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module im_loader
  import im_loader_pkg::*;
#(
  parameter int          DEPTH     = IM_DEPTH_DEFAULT,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  im_loader_if.master bus,
  output logic        core_hold,
  output logic        done,
  output logic        err
);

  // One extra bit so cnt can reach DEPTH and park there without wrapping.
  localparam int            CW   = cnt_w(DEPTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

`ifdef IM_LOADER_VERIFY_EN
  localparam bit VERIFY_EN = 1'b1;
`else
  localparam bit VERIFY_EN = 1'b0;
`endif

  state_t            state;
  state_t            state_nx;
  logic [CW-1:0]     cnt;
  logic [31:0]       addr_q;
  logic              wr_q;
  logic [WORD_W-1:0] data_q;
  logic              accept;
  logic              start_load;
  logic [WORD_W-1:0] wr_sum;

  function automatic logic [31:0] word_addr(input logic [CW-1:0] idx);
    return BASE_ADDR + (32'(idx) << 2);
  endfunction

  assign start_load      = start && ((state == IDLE) || (state == DONE));
  assign bus.in_ready    = (state == LOAD) && (cnt != FULL);
  assign accept          = bus.in_valid && bus.in_ready;
  assign bus.im_addr     = addr_q;
  assign bus.im_memWrite = wr_q;
  assign bus.im_dataIn   = data_q;
  assign core_hold       = (state != DONE);
  assign done            = (state == DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = LOAD;
      LOAD:    if (cnt == FULL) state_nx = VERIFY_EN ? VERIFY : DONE;
      VERIFY:  if (cnt == LAST) state_nx = DONE;
      DONE:    if (start) state_nx = LOAD;
      default: state_nx = IDLE;
    endcase
  end

  // Write strobe is a single-cycle pulse per accepted word; address holds in gaps.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt    <= '0;
      addr_q <= BASE_ADDR;
      wr_q   <= 1'b0;
      data_q <= '0;
    end else begin
      wr_q <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) cnt <= '0;
        end
        LOAD: begin
          if (accept) begin
            wr_q   <= 1'b1;
            addr_q <= word_addr(cnt);
            data_q <= bus.in_data;
            cnt    <= cnt + 1'b1;
          end else if (cnt == FULL && VERIFY_EN) begin
            cnt    <= '0;
            addr_q <= BASE_ADDR;
          end
        end
        VERIFY: begin
          if (cnt != LAST) begin
            cnt    <= cnt + 1'b1;
            addr_q <= word_addr(cnt + 1'b1);
          end
        end
        default: ;
      endcase
    end
  end

  im_loader_xsum u_wr_xsum (
    .clk   (clk),
    .reset (reset),
    .clr   (start_load),
    .en    (accept),
    .din   (bus.in_data),
    .sum   (wr_sum)
  );

`ifdef IM_LOADER_VERIFY_EN
  logic [WORD_W-1:0] rb_sum;

  im_loader_xsum u_rb_xsum (
    .clk   (clk),
    .reset (reset),
    .clr   (start_load),
    .en    (state == VERIFY),
    .din   (bus.im_rdata),
    .sum   (rb_sum)
  );

  // The final readback word is folded in combinationally at the deciding edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err <= 1'b0;
    end else if (start_load) begin
      err <= 1'b0;
    end else if (state == VERIFY && cnt == LAST) begin
      err <= ((rb_sum ^ bus.im_rdata) != wr_sum);
    end
  end
`else
  logic unused_sum;
  assign unused_sum = ^{wr_sum, bus.im_rdata};
  assign err        = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_im_loader.sv
// ============================================================================
// tb_im_loader : table-driven random-stall loads checked against an IM image model
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_im_loader;

  localparam int DEPTH = 16;
`ifdef IM_LOADER_VERIFY_EN
  localparam int DONE_LAT  = DEPTH + 1;
  localparam bit VERIFY_ON = 1'b1;
`else
  localparam int DONE_LAT  = 1;
  localparam bit VERIFY_ON = 1'b0;
`endif

  typedef struct {
    int stall;      // 0 none, 1 alternate, 2 random
    int kind;       // 0 0x1000_0000+i, 1 random, 2 pattern
    bit corrupt;    // flip bit 0 of readback word 3
    bit extra;      // keep in_valid high after the last word
    bit start_mid;  // pulse start during LOAD
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic clk     = 1'b0;
  logic reset   = 1'b0;
  logic start   = 1'b0;
  logic corrupt = 1'b0;
  logic core_hold;
  logic done;
  logic err;

  im_loader_if bus ();

  logic [31:0] im_mem [DEPTH];
  wr_t         log_q [$];
  int          cyc    = 0;
  int          checks = 0;
  int          errors = 0;

  im_loader #(.DEPTH(DEPTH), .BASE_ADDR(32'h0)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bus       (bus.master),
    .core_hold (core_hold),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // IM model: captures on the negedge after the write strobe; reads are combinational.
  always @(negedge clk) begin
    if (bus.im_memWrite) begin
      im_mem[bus.im_addr[5:2]] <= bus.im_dataIn;
      log_q.push_back('{bus.im_addr, bus.im_dataIn});
    end
  end

  assign bus.im_rdata = im_mem[bus.im_addr[5:2]] ^
                        {31'b0, (corrupt && bus.im_addr[5:2] == 4'd3)};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    logic [31:0] words [DEPTH];
    int idx;
    int n;
    int p;
    int t;
    bit ok;
    for (int i = 0; i < DEPTH; i++) begin
      case (v.kind)
        0:       words[i] = 32'h1000_0000 + 32'(i);
        1:       words[i] = $urandom;
        default: words[i] = ~(32'(i) * 32'h0101_0101);
      endcase
    end
    corrupt = v.corrupt;
    log_q.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("hold_after_start", {31'b0, core_hold}, 32'd1);
    chk("done_after_start", {31'b0, done}, 32'd0);
    chk("err_cleared", {31'b0, err}, 32'd0);

    idx = 0;
    n   = 0;
    p   = 0;
    while (idx < DEPTH && n < 1000) begin
      case (v.stall)
        0:       bus.in_valid = 1'b1;
        1:       bus.in_valid = (n % 2 == 0);
        default: bus.in_valid = 1'($urandom_range(0, 1));
      endcase
      bus.in_data = words[idx];
      start       = v.start_mid && (idx == 5);
      if (bus.in_valid && bus.in_ready) begin
        idx++;
        if (idx == DEPTH) p = cyc + 1;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    if (idx != DEPTH) chk("load_timeout", 32'(idx), 32'(DEPTH));

    chk("ready_low_after_last", {31'b0, bus.in_ready}, 32'd0);
    chk("last_write_en", {31'b0, bus.im_memWrite}, 32'd1);
    chk("last_write_addr", bus.im_addr, 32'(4 * (DEPTH - 1)));

    bus.in_valid = v.extra;
    bus.in_data  = 32'hDEAD_BEEF;
    t = 0;
    while (!done && t < 200) begin
      @(negedge clk);
      t++;
    end
    bus.in_valid = 1'b0;

    chk("done_latency", 32'(cyc - p), 32'(DONE_LAT));
    chk("done", {31'b0, done}, 32'd1);
    chk("core_hold_released", {31'b0, core_hold}, 32'd0);
    chk("err", {31'b0, err}, {31'b0, VERIFY_ON && v.corrupt});
    chk("ready_in_done", {31'b0, bus.in_ready}, 32'd0);
    chk("write_count", 32'(log_q.size()), 32'(DEPTH));
    ok = 1'b1;
    for (int i = 0; i < log_q.size() && i < DEPTH; i++) begin
      if (log_q[i].addr !== 32'(4 * i) || log_q[i].data !== words[i]) ok = 1'b0;
    end
    chk("write_sequence", {31'b0, ok}, 32'd1);
    ok = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      if (im_mem[i] !== words[i]) ok = 1'b0;
    end
    chk("im_image", {31'b0, ok}, 32'd1);
    chk("im_word5", im_mem[5], words[5]);
    @(negedge clk);
    chk("done_stays", {31'b0, done}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [5];
    int   idx;
    int   n;

    vecs[0] = '{0, 0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1, 0, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{2, 1, 1'b0, 1'b1, 1'b1};
    vecs[3] = '{0, 1, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{2, 2, 1'b0, 1'b0, 1'b1};

    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (3) @(negedge clk);
    chk("rst_core_hold", {31'b0, core_hold}, 32'd1);
    chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd0);
    chk("rst_memwrite", {31'b0, bus.im_memWrite}, 32'd0);
    chk("rst_addr", bus.im_addr, 32'h0);
    chk("rst_datain", bus.im_dataIn, 32'h0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_hold", {31'b0, core_hold}, 32'd1);
    chk("idle_ready", {31'b0, bus.in_ready}, 32'd0);

    run_vec(vecs[0]);

    // Abort a reload after eight words, then reload from IDLE.
    log_q.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    idx = 0;
    n   = 0;
    while (idx < 8 && n < 100) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 32'hA000_0000 + 32'(idx);
      if (bus.in_ready) idx++;
      @(negedge clk);
      n++;
    end
    bus.in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("abort_core_hold", {31'b0, core_hold}, 32'd1);
    chk("abort_in_ready", {31'b0, bus.in_ready}, 32'd0);
    chk("abort_memwrite", {31'b0, bus.im_memWrite}, 32'd0);
    chk("abort_addr", bus.im_addr, 32'h0);
    chk("abort_datain", bus.im_dataIn, 32'h0);
    chk("abort_done", {31'b0, done}, 32'd0);
    chk("abort_partial_writes", 32'(log_q.size()), 32'd8);
    chk("abort_word7", im_mem[7], 32'hA000_0007);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    for (int k = 1; k < 5; k++) run_vec(vecs[k]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
